// File: rtl/dist_ram_pkg.sv
// Shared definitions for the multi-port distributed RAM.
//   clr_state_e : clear sequencer state encoding (IDLE=0, CLEAR=1).
package dist_ram_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } clr_state_e;

endpackage

// File: rtl/dist_ram_clr_seq.sv
// Clear sequencer for dist_ram_mport: walks every entry once, driving the
// sweep address, whenever reset or a clear request starts a sweep.
// Ports:
//   clk_i, rst_i : clock, synchronous active-high reset (starts a sweep)
//   clr_i        : one-cycle clear request, honoured only in IDLE
//   busy_o       : high while the sweep is in progress
//   cnt_o        : entry being zeroed on the current edge
module dist_ram_clr_seq
  import dist_ram_pkg::*;
#(
  parameter int unsigned ENTRY_NUM = 32,
  parameter int unsigned AWDTH     = $clog2(ENTRY_NUM)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clr_i,
  output logic             busy_o,
  output logic [AWDTH-1:0] cnt_o
);

  localparam logic [AWDTH-1:0] LAST = AWDTH'(ENTRY_NUM - 1);

  clr_state_e       state;
  clr_state_e       state_next;
  logic [AWDTH-1:0] cnt;
  logic [AWDTH-1:0] cnt_next;

  // State register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= CLEAR;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // Next-state logic; clr_i during CLEAR neither restarts nor extends
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    unique case (state)
      IDLE: begin
        if (clr_i) begin
          state_next = CLEAR;
          cnt_next   = '0;
        end
      end
      CLEAR: begin
        cnt_next = cnt + 1'b1;
        if (cnt == LAST) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Outputs
  always_comb begin
    busy_o = (state == CLEAR);
    cnt_o  = cnt;
  end

endmodule

// File: rtl/dist_ram_mport.sv
// Multi-read-port distributed RAM with byte-enable writes, optional
// write-to-read forwarding and a sequenced whole-array clear.
// Ports:
//   clk_i, rst_i  : clock, synchronous active-high reset (triggers a clear sweep)
//   we_i          : write request (dropped while busy_o)
//   write_addr_i  : write entry index
//   be_i          : byte enables, bit k covers data bits [8k+7:8k]
//   data_i        : write data
//   read_addr_i   : packed read addresses, port p uses slice p
//   data_o        : packed asynchronous read data, port p uses slice p
//   clr_i         : one-cycle request to zero the array
//   busy_o        : high while the clear sweep runs; reads return 0 then
module dist_ram_mport
  import dist_ram_pkg::*;
#(
  parameter int unsigned XLEN      = 32,
  parameter int unsigned ENTRY_NUM = 32,
  parameter int unsigned NRD       = 2,
  parameter int unsigned BYPASS    = 1
) (
  input  logic                                  clk_i,
  input  logic                                  rst_i,
  input  logic                                  we_i,
  input  logic [$clog2(ENTRY_NUM)-1:0]          write_addr_i,
  input  logic [XLEN/8-1:0]                     be_i,
  input  logic [XLEN-1:0]                       data_i,
  input  logic [NRD*$clog2(ENTRY_NUM)-1:0]      read_addr_i,
  output logic [NRD*XLEN-1:0]                   data_o,
  input  logic                                  clr_i,
  output logic                                  busy_o
);

  localparam int unsigned AWDTH = $clog2(ENTRY_NUM);
  localparam int unsigned NBE   = XLEN / 8;

  logic             busy;
  logic [AWDTH-1:0] sweep_addr;
  logic             accept;
  logic [XLEN-1:0]  old_word;
  logic [XLEN-1:0]  merged_word;

  // No reset on the array so it stays inferable as distributed RAM
  logic [XLEN-1:0]  mem [ENTRY_NUM];

  dist_ram_clr_seq #(
    .ENTRY_NUM (ENTRY_NUM),
    .AWDTH     (AWDTH)
  ) u_clr_seq (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .clr_i  (clr_i),
    .busy_o (busy),
    .cnt_o  (sweep_addr)
  );

  assign busy_o = busy;
  assign accept = we_i & ~busy;

  // Word as it will look after this cycle's write; feeds the bypass path
  always_comb begin
    old_word    = mem[write_addr_i];
    merged_word = old_word;
    for (int unsigned b = 0; b < NBE; b++) begin
      if (be_i[b]) begin
        merged_word[b*8 +: 8] = data_i[b*8 +: 8];
      end
    end
  end

  // Single write port: the sweep owns it while busy, user writes otherwise
  always_ff @(posedge clk_i) begin
    if (busy) begin
      mem[sweep_addr] <= '0;
    end else if (accept) begin
      for (int unsigned b = 0; b < NBE; b++) begin
        if (be_i[b]) begin
          mem[write_addr_i][b*8 +: 8] <= data_i[b*8 +: 8];
        end
      end
    end
  end

  // Asynchronous read ports; zero while busy hides a partially cleared array
  always_comb begin
    logic [AWDTH-1:0] raddr;
    raddr  = '0;
    data_o = '0;
    for (int unsigned p = 0; p < NRD; p++) begin
      raddr = read_addr_i[p*AWDTH +: AWDTH];
      if (busy) begin
        data_o[p*XLEN +: XLEN] = '0;
      end else if ((BYPASS != 0) && accept && (raddr == write_addr_i)) begin
        data_o[p*XLEN +: XLEN] = merged_word;
      end else begin
        data_o[p*XLEN +: XLEN] = mem[raddr];
      end
    end
  end

endmodule

// File: tb/tb_dist_ram_mport.sv
// Self-checking bench for dist_ram_mport: two instances (forwarding on and
// off) share all inputs and are compared every cycle against a behavioural
// model of the array, plus directed scenarios with literal expectations.
module tb_dist_ram_mport;

  localparam int unsigned XLEN      = 32;
  localparam int unsigned ENTRY_NUM = 32;
  localparam int unsigned NRD       = 4;
  localparam int unsigned AWDTH     = 5;
  localparam int unsigned NBE       = 4;

  logic                   clk = 1'b0;
  logic                   rst = 1'b1;
  logic                   we = 1'b0;
  logic                   clr = 1'b0;
  logic [AWDTH-1:0]       waddr = '0;
  logic [NBE-1:0]         be = '0;
  logic [XLEN-1:0]        wdata = '0;
  logic [NRD*AWDTH-1:0]   raddr = '0;
  logic [NRD*XLEN-1:0]    q_byp;
  logic [NRD*XLEN-1:0]    q_nobyp;
  logic                   busy_byp;
  logic                   busy_nobyp;

  int checks = 0;
  int errors = 0;

  // Behavioural model: contents plus remaining sweep cycles
  logic [XLEN-1:0] mdl [ENTRY_NUM];
  int              busy_left = 0;
  bit              known = 1'b0;

  always #5 clk = ~clk;

  dist_ram_mport #(
    .XLEN(XLEN), .ENTRY_NUM(ENTRY_NUM), .NRD(NRD), .BYPASS(1)
  ) dut_byp (
    .clk_i(clk), .rst_i(rst), .we_i(we), .write_addr_i(waddr), .be_i(be),
    .data_i(wdata), .read_addr_i(raddr), .data_o(q_byp), .clr_i(clr),
    .busy_o(busy_byp)
  );

  dist_ram_mport #(
    .XLEN(XLEN), .ENTRY_NUM(ENTRY_NUM), .NRD(NRD), .BYPASS(0)
  ) dut_nobyp (
    .clk_i(clk), .rst_i(rst), .we_i(we), .write_addr_i(waddr), .be_i(be),
    .data_i(wdata), .read_addr_i(raddr), .data_o(q_nobyp), .clr_i(clr),
    .busy_o(busy_nobyp)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [XLEN-1:0] model_read(input int p, input bit byp);
    logic [AWDTH-1:0] a;
    logic [XLEN-1:0]  w;
    a = raddr[p*AWDTH +: AWDTH];
    if (busy_left > 0) return '0;
    w = mdl[a];
    if (byp && we && (a == waddr)) begin
      for (int b = 0; b < NBE; b++) if (be[b]) w[b*8 +: 8] = wdata[b*8 +: 8];
    end
    return w;
  endfunction

  // Model update on each edge
  always @(posedge clk) begin
    if (rst) begin
      busy_left = ENTRY_NUM;
      for (int i = 0; i < ENTRY_NUM; i++) mdl[i] = '0;
      known = 1'b1;
    end else if (busy_left > 0) begin
      busy_left = busy_left - 1;
    end else begin
      if (we) begin
        for (int b = 0; b < NBE; b++) if (be[b]) mdl[waddr][b*8 +: 8] = wdata[b*8 +: 8];
      end
      if (clr) begin
        busy_left = ENTRY_NUM;
        for (int i = 0; i < ENTRY_NUM; i++) mdl[i] = '0;
      end
    end
  end

  // Per-cycle compare against the model
  always @(negedge clk) begin
    if (known) begin
      check("busy_byp", 32'(busy_byp), 32'(busy_left > 0));
      check("busy_nobyp", 32'(busy_nobyp), 32'(busy_left > 0));
      for (int p = 0; p < NRD; p++) begin
        check($sformatf("rd_byp[%0d]", p), q_byp[p*XLEN +: XLEN], model_read(p, 1'b1));
        check($sformatf("rd_nobyp[%0d]", p), q_nobyp[p*XLEN +: XLEN], model_read(p, 1'b0));
      end
    end
  end

  task automatic drive_idle();
    we = 1'b0; clr = 1'b0; rst = 1'b0; be = '0; wdata = '0;
  endtask

  task automatic count_busy(output int n);
    n = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (!busy_byp) break;
      n++;
    end
  endtask

  task automatic check_all_zero(input string name);
    for (int a = 0; a < ENTRY_NUM; a += NRD) begin
      @(posedge clk); #1;
      for (int p = 0; p < NRD; p++) raddr[p*AWDTH +: AWDTH] = AWDTH'(a + p);
      @(negedge clk);
      for (int p = 0; p < NRD; p++) check(name, q_byp[p*XLEN +: XLEN], 32'h0);
    end
  endtask

  task automatic write_word(input int a, input logic [31:0] d, input logic [3:0] e);
    @(posedge clk); #1;
    we = 1'b1; waddr = AWDTH'(a); wdata = d; be = e;
  endtask

  initial begin
    int n;
    // Reset for two cycles
    @(negedge clk);
    check("busy_in_reset", 32'(busy_byp), 32'h1);
    @(posedge clk); #1;
    drive_idle();
    count_busy(n);
    check("reset_busy_len", 32'(n), 32'd32);
    check_all_zero("reset_zero");

    // Byte enables
    write_word(5, 32'hAABBCCDD, 4'b1111);
    write_word(5, 32'h11223344, 4'b0101);
    @(posedge clk); #1;
    drive_idle();
    raddr = '0;
    raddr[0 +: AWDTH] = 5'd5;
    raddr[3*AWDTH +: AWDTH] = 5'd5;
    @(negedge clk);
    check("be_merge_p0", q_byp[31:0], 32'hAA22CC44);
    check("be_merge_p3", q_nobyp[127:96], 32'hAA22CC44);
    check("be_model_pin", mdl[5], 32'hAA22CC44);

    // Same-cycle forwarding on port 1
    write_word(7, 32'hDEADBEEF, 4'b1111);
    raddr = '0;
    raddr[AWDTH +: AWDTH] = 5'd7;
    @(negedge clk);
    check("bypass_on", q_byp[63:32], 32'hDEADBEEF);
    check("bypass_off_old", q_nobyp[63:32], 32'h0);
    @(posedge clk); #1;
    drive_idle();
    @(negedge clk);
    check("bypass_off_after", q_nobyp[63:32], 32'hDEADBEEF);

    // Fill, then clear with interference during the sweep
    for (int a = 0; a < ENTRY_NUM; a++) write_word(a, 32'(a), 4'b1111);
    @(posedge clk); #1;
    drive_idle();
    raddr = '0;
    raddr[2*AWDTH +: AWDTH] = 5'd9;
    @(negedge clk);
    check("fill_addr9", q_byp[95:64], 32'd9);
    @(posedge clk); #1;
    clr = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0;
    n = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (!busy_byp) break;
      n++;
      #1;
      if (n == 5) begin
        we = 1'b1; waddr = 5'd3; wdata = 32'hFFFFFFFF; be = 4'hF; clr = 1'b1;
      end else if (n == 6) begin
        drive_idle();
      end
    end
    check("clear_busy_len", 32'(n), 32'd32);
    check_all_zero("clear_zero");

    // Reset in the middle of a sweep
    @(posedge clk); #1;
    clr = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0;
    repeat (10) @(negedge clk);
    check("midsweep_busy", 32'(busy_byp), 32'h1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    count_busy(n);
    check("midsweep_busy_len", 32'(n), 32'd32);

    // Randomized traffic on all four ports
    for (int i = 0; i < 10000; i++) begin
      @(posedge clk); #1;
      we    = 1'($urandom_range(0, 1));
      waddr = AWDTH'($urandom);
      be    = NBE'($urandom);
      wdata = $urandom;
      raddr = (NRD*AWDTH)'($urandom);
      if ($urandom_range(0, 3) == 0) raddr[AWDTH*$urandom_range(0, NRD-1) +: AWDTH] = waddr;
      clr   = ($urandom_range(0, 299) == 0);
      rst   = ($urandom_range(0, 1999) == 0);
    end
    @(posedge clk); #1;
    drive_idle();
    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
